delay_scheduler: RTL

DELAY_SCHEDULER -- requirements
Module: delay_scheduler

---
 rtl/delay_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/delay_scheduler.sv
// Shared delay counter time-sliced among four requesters with round-robin
// arbitration; counts 10 ms ticks down from the winner's delay field.
module delay_scheduler #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] dly,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic            busy,
  output logic [DW-1:0]   remain
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      owner_r;
  logic [1:0]      last_r;
  logic [1:0]      winner_s;
  logic [DW-1:0]   cnt_r;
  logic [DW-1:0]   dly_sel_s;
  logic            owner_req_s;

  // First requester found ascending from last+1 with wrap; last itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Arbitration winner, owner's delay field and owner's request level.
  always_comb begin
    winner_s    = rr_pick(req, last_r);
    dly_sel_s   = dly[owner_r*DW +: DW];
    owner_req_s = req[owner_r];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a dropped owner request aborts before completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) state_s = LOAD;
        else                state_s = IDLE;
      end
      LOAD: begin
        if (!owner_req_s) state_s = IDLE;
        else              state_s = RUN;
      end
      RUN: begin
        if (!owner_req_s)            state_s = IDLE;
        else if (cnt_r == {DW{1'b0}}) state_s = DONE;
        else                          state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Owner, priority pointer and down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= 2'd0;
      last_r  <= 2'd3;
      cnt_r   <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req != 4'b0000) owner_r <= winner_s;
        end
        LOAD: begin
          if (owner_req_s) cnt_r  <= dly_sel_s;
          else             last_r <= owner_r;
        end
        RUN: begin
          if (!owner_req_s)
            last_r <= owner_r;
          else if (tick && (cnt_r != {DW{1'b0}}))
            cnt_r <= cnt_r - {{(DW-1){1'b0}}, 1'b1};
        end
        DONE: begin
          last_r <= owner_r;
        end
        default: begin
          owner_r <= 2'd0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    gnt    = 4'b0000;
    done   = 4'b0000;
    busy   = 1'b0;
    remain = cnt_r;
    case (state_r)
      LOAD, RUN: begin
        gnt  = 4'b0001 << owner_r;
        busy = 1'b1;
      end
      DONE: begin
        done = 4'b0001 << owner_r;
      end
      default: begin
        gnt = 4'b0000;
      end
    endcase
  end

endmodule
